// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer: FIFO entry layout, FSM states, alignment helper.
// Optional statistics counters are enabled with PREFETCH_STATS_EN.
package inst_prefetch_buffer_pkg;

  localparam int unsigned FETCH_WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pf_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Core-side valid/ready and memory-side req/gnt/rvalid signals of the prefetch buffer.
// master = prefetch buffer, slave = surrounding core and instruction memory.
interface inst_prefetch_buffer_if;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    input  redirect_i, redirect_addr_i, instr_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_valid_o, instr_rdata_o, instr_addr_o, mem_req_o, mem_addr_o
  );

  modport slave (
    output redirect_i, redirect_addr_i, instr_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_valid_o, instr_rdata_o, instr_addr_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/inst_prefetch_buffer_fifo.sv
// Fetch-entry FIFO: push/pop/flush, head visible combinationally, 1-cycle push-to-head latency.
// Simultaneous push and pop is accepted when full; head reads as zero while empty.
module prefetch_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  // Storage is not reset, so mask the head to keep outputs at zero while empty.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher with redirect flush; response-to-valid 1 cycle, redirect-to-request 1 cycle.
// Issue is credit-limited by FIFO space and MAX_OUTSTANDING; PREFETCH_STATS_EN adds fetched/dropped counters.
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              boot_addr,
  inst_prefetch_buffer_if.master   bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]              stat_fetched_o,
  output logic [31:0]              stat_dropped_o
`endif
);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = ((OW > CW) ? OW : CW) + 1;

  pf_state_e    state_q, state_d;
  logic [31:0]  fetch_ptr_q, fetch_ptr_d;
  logic [31:0]  resp_addr_q, resp_addr_d;
  logic [31:0]  hold_addr_q, hold_addr_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic         hold_q, hold_d;
  logic         stale_q, stale_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  fifo_head, fifo_in;
  logic [SW-1:0] inflight;
  logic          can_issue, gnt, rsp, push, pop;

  assign inflight  = SW'(fifo_count) + SW'(outst_q) - SW'(drop_q);
  assign can_issue = (state_q == ST_RUN) && (outst_q < OW'(MAX_OUTSTANDING))
                     && (inflight < SW'(DEPTH));

  // A request that was not granted stays on the bus with its original address.
  assign bus.mem_req_o  = hold_q | can_issue;
  assign bus.mem_addr_o = hold_q ? hold_addr_q : fetch_ptr_q;

  assign gnt  = bus.mem_req_o & bus.mem_gnt_i;
  assign rsp  = bus.mem_rvalid_i;
  assign push = rsp & (drop_q == '0) & ~bus.redirect_i & (~fifo_full | pop);
  assign pop  = ~fifo_empty & bus.instr_ready_i & ~bus.redirect_i;

  assign fifo_in = '{rdata: bus.mem_rdata_i, addr: resp_addr_q};

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (fifo_in),
    .pop_i      (pop),
    .flush_i    (bus.redirect_i),
    .head_dat_o (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign bus.instr_valid_o = ~fifo_empty;
  assign bus.instr_rdata_o = fifo_head.rdata;
  assign bus.instr_addr_o  = fifo_head.addr;

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    resp_addr_d = resp_addr_q;
    hold_addr_d = hold_addr_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    hold_d      = hold_q;
    stale_d     = stale_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d     = ST_RUN;
        fetch_ptr_d = word_align(boot_addr);
        resp_addr_d = word_align(boot_addr);
      end
      default: begin
        outst_d     = outst_q + OW'(gnt) - OW'(rsp);
        hold_d      = bus.mem_req_o & ~bus.mem_gnt_i;
        hold_addr_d = bus.mem_addr_o;
        if (bus.redirect_i) begin
          fetch_ptr_d = word_align(bus.redirect_addr_i);
          resp_addr_d = word_align(bus.redirect_addr_i);
          drop_d      = outst_q - OW'(rsp) + OW'(gnt);
          // A still-pending request now points at the old stream; its data must be dropped.
          stale_d     = hold_d;
        end else begin
          if (gnt && !stale_q) fetch_ptr_d = fetch_ptr_q + 32'(FETCH_WORD_BYTES);
          if (push)            resp_addr_d = resp_addr_q + 32'(FETCH_WORD_BYTES);
          drop_d  = drop_q - OW'(rsp && (drop_q != '0)) + OW'(gnt && stale_q);
          stale_d = stale_q & hold_d;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      fetch_ptr_q <= '0;
      resp_addr_q <= '0;
      hold_addr_q <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      hold_q      <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      resp_addr_q <= resp_addr_d;
      hold_addr_q <= hold_addr_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      hold_q      <= hold_d;
      stale_q     <= stale_d;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] fetched_q, dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      if (push && (fetched_q != '1))        fetched_q <= fetched_q + 32'd1;
      if (rsp && !push && (dropped_q != '1)) dropped_q <= dropped_q + 32'd1;
    end
  end

  assign stat_fetched_o = fetched_q;
  assign stat_dropped_o = dropped_q;
`endif

endmodule
